// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the sys_bridge CPU-to-device bridge.
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F00;
  localparam int unsigned DEF_DEV_SPAN  = 32'd16;

  // Byte offset of the IRQ register from BASE_ADDR: first window past the last slot.
  function automatic int unsigned irq_reg_offset(input int unsigned n_dev, input int unsigned span);
    return n_dev * span;
  endfunction

  localparam int unsigned DEF_IRQ_OFFSET = irq_reg_offset(32'd2, DEF_DEV_SPAN);

  function automatic int unsigned slot_width(input int unsigned n_dev);
    return (n_dev <= 32'd1) ? 32'd1 : $clog2(n_dev);
  endfunction

endpackage

// File: rtl/sys_bridge_irq.sv
// Interrupt collection for sys_bridge: sticky pending bits with write-1-to-clear
// when SYS_BRIDGE_IRQ_LATCH_EN is defined, otherwise a single delay stage.
module sys_bridge_irq
  import sys_bridge_pkg::*;
#(
  parameter int unsigned N_DEV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DEV-1:0] dev_irq,
  input  logic             clr_en,
  input  logic [N_DEV-1:0] clr_mask,
  output logic [N_DEV-1:0] irq_out
);

`ifdef SYS_BRIDGE_IRQ_LATCH_EN
  logic [N_DEV-1:0] clr_s;

  // Clear mask is only live during an accepted IRQ register write.
  always_comb begin
    clr_s = {N_DEV{1'b0}};
    if (clr_en) begin
      clr_s = clr_mask;
    end else begin
      clr_s = {N_DEV{1'b0}};
    end
  end

  // Pending register; a same-cycle set overrides the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_out <= {N_DEV{1'b0}};
    end else begin
      irq_out <= (irq_out & ~clr_s) | dev_irq;
    end
  end
`else
  logic unused_clr_s;
  assign unused_clr_s = ^{clr_en, clr_mask};

  // One register stage between device lines and the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_out <= {N_DEV{1'b0}};
    end else begin
      irq_out <= dev_irq;
    end
  end
`endif

endmodule

// File: rtl/sys_bridge.sv
// sys_bridge: decodes CPU data accesses into N_DEV device windows with req/ack
// handshake and timeout. IRQ register decode depends on SYS_BRIDGE_IRQ_LATCH_EN.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int unsigned N_DEV     = 2,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned DEV_SPAN  = DEF_DEV_SPAN,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic [3:0]                  cpu_byteen,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_ready,
  output logic                        cpu_err,
  output logic [N_DEV-1:0]            dev_sel,
  output logic                        dev_we,
  output logic [$clog2(DEV_SPAN)-1:0] dev_addr,
  output logic [31:0]                 dev_wdata,
  output logic [3:0]                  dev_byteen,
  input  logic [32*N_DEV-1:0]         dev_rdata,
  input  logic [N_DEV-1:0]            dev_ack,
  input  logic [N_DEV-1:0]            dev_irq,
  output logic [N_DEV-1:0]            irq_out
);

  localparam int unsigned AW = $clog2(DEV_SPAN);
  localparam int unsigned SW = slot_width(N_DEV);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r, state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [SW-1:0]    slot_r;
  logic [31:0]      offset_s, slot_full_s, sel_rdata_s, irq_rd_s, resp_data_s;
  logic [SW-1:0]    slot_s;
  logic [N_DEV-1:0] sel_dec_s;
  logic             hit_s, irq_hit_s, misalign_s, ack_sel_s;
  logic             accept_s, resp_err_s, irq_clr_en_s;

  // Unsigned subtraction makes addresses below BASE_ADDR land on a huge slot index.
  assign offset_s    = cpu_addr - BASE_ADDR;
  assign slot_full_s = offset_s >> AW;
  assign slot_s      = slot_full_s[SW-1:0];
  assign hit_s       = (slot_full_s < 32'(N_DEV));
  assign misalign_s  = (cpu_byteen == 4'b1111) && (cpu_addr[1:0] != 2'b00);
  assign sel_rdata_s = dev_rdata[{slot_r, 5'b00000} +: 32];
  assign ack_sel_s   = dev_ack[slot_r];
  assign irq_rd_s    = {{(32-N_DEV){1'b0}}, irq_out};

`ifdef SYS_BRIDGE_IRQ_LATCH_EN
  localparam logic [31:0] IRQ_OFF = 32'(irq_reg_offset(N_DEV, DEV_SPAN));
  assign irq_hit_s = (offset_s[31:2] == IRQ_OFF[31:2]);
`else
  assign irq_hit_s = 1'b0;
`endif

  // One-hot slot decode of the incoming address.
  always_comb begin
    sel_dec_s = {N_DEV{1'b0}};
    for (int i = 0; i < N_DEV; i++) begin
      sel_dec_s[i] = (slot_full_s == 32'(i));
    end
  end

  // Next-state and response selection.
  always_comb begin
    state_next_s = state_r;
    resp_err_s   = 1'b0;
    resp_data_s  = 32'h0000_0000;
    accept_s     = 1'b0;
    irq_clr_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          if (misalign_s) begin
            state_next_s = ST_RESP;
            resp_err_s   = 1'b1;
          end else if (hit_s) begin
            state_next_s = ST_ACCESS;
            accept_s     = 1'b1;
          end else if (irq_hit_s) begin
            state_next_s = ST_RESP;
            if (cpu_we) begin
              irq_clr_en_s = 1'b1;
            end else begin
              resp_data_s = irq_rd_s;
            end
          end else begin
            state_next_s = ST_RESP;
            resp_err_s   = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ack_sel_s) begin
          state_next_s = ST_RESP;
          resp_data_s  = sel_rdata_s;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_RESP;
          resp_err_s   = 1'b1;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and wait counter; counter is held at zero outside ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_ACCESS) && (state_next_s == ST_ACCESS)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  // Registered CPU response and device-side request copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'h0000_0000;
      dev_sel    <= {N_DEV{1'b0}};
      dev_we     <= 1'b0;
      dev_addr   <= {AW{1'b0}};
      dev_wdata  <= 32'h0000_0000;
      dev_byteen <= 4'b0000;
      slot_r     <= {SW{1'b0}};
    end else begin
      cpu_ready <= (state_next_s == ST_RESP);
      cpu_err   <= resp_err_s;
      cpu_rdata <= resp_data_s;
      if (accept_s) begin
        dev_sel    <= sel_dec_s;
        dev_we     <= cpu_we;
        dev_addr   <= offset_s[AW-1:0];
        dev_wdata  <= cpu_wdata;
        dev_byteen <= cpu_byteen;
        slot_r     <= slot_s;
      end else if (state_next_s != ST_ACCESS) begin
        dev_sel <= {N_DEV{1'b0}};
      end else begin
        dev_sel <= dev_sel;
      end
    end
  end

  sys_bridge_irq #(.N_DEV(N_DEV)) u_irq (
    .clk      (clk),
    .reset    (reset),
    .dev_irq  (dev_irq),
    .clr_en   (irq_clr_en_s),
    .clr_mask (cpu_wdata[N_DEV-1:0]),
    .irq_out  (irq_out)
  );

endmodule

// File: doc/sys_bridge.md
# sys_bridge

Parametrised system bridge between the CPU data port and N memory-mapped devices, replacing the fixed CPU-to-data-memory wiring in the `mips` top level. It decodes each CPU access into one device window and runs a request/acknowledge handshake with a timeout. It returns registered read data or an error, and collects device interrupts into a pending register. The bridge sits beside the data memory in the top level; `cpu` drives it through a req/ready handshake.

## Interface
- `N_DEV`, 2, number of device slots (1..8)
- `BASE_ADDR`, 32'h0000_7F00, byte address of device 0 window
- `DEV_SPAN`, 16, bytes per device window (power of two, ≥4)
- `TIMEOUT`, 15, maximum ACCESS cycles waiting for `dev_ack` (≥1)

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately
- `cpu_req` in 1: access request; held high until `cpu_ready`
- `cpu_we` in 1: 1 = write
- `cpu_addr` in 32: byte address
- `cpu_wdata` in 32: write data
- `cpu_byteen` in 4: byte enables
- `cpu_rdata` out 32: read data, valid only while `cpu_ready`
- `cpu_ready` out 1: one-cycle completion pulse
- `cpu_err` out 1: qualifies `cpu_ready`; marks an error response (decode miss, misaligned, or timeout)
- `dev_sel` out N_DEV: one-hot select, high throughout ACCESS
- `dev_we` out 1, `dev_addr` out log2(DEV_SPAN), `dev_wdata` out 32, `dev_byteen` out 4: registered copies of the request; `dev_addr` is the window offset
- `dev_rdata` in 32*N_DEV: packed; slot i at [32i+31:32i]
- `dev_ack` in N_DEV: device completion, sampled only for the selected slot
- `dev_irq` in N_DEV: level interrupt requests
- `irq_out` out N_DEV: interrupt lines to the CPU

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- In IDLE, `cpu_req` is sampled every edge and the request is decoded:
  - Slot index = (addr − BASE_ADDR)/DEV_SPAN. A slot index ≥ N_DEV is a miss.
  - The IRQ register sits at BASE_ADDR + N_DEV·DEV_SPAN. It is decoded only when the macro below is defined.
  - A request with `cpu_byteen`==4'b1111 and addr[1:0]≠0 is misaligned.
- Hit: register the request fields, assert `dev_sel[i]`, go to ACCESS.
- Miss or misaligned: go to RESP with error. No `dev_sel` is raised, so a write has no side effect.
- IRQ register access: go to RESP with no error. A read returns the zero-extended pending vector. A write clears the pending bits where `cpu_wdata` has a 1.
- In ACCESS, the wait counter starts at 0 and increments each cycle.
  - `dev_ack[i]` high: latch `dev_rdata` slot i, go to RESP with no error.
  - Otherwise, when the counter reaches TIMEOUT−1: go to RESP with error and `cpu_rdata`=0.
  - An ack arriving in the same cycle as the timeout wins.
- In RESP: `cpu_ready`=1 for exactly one cycle, with `cpu_err` and `cpu_rdata` valid. Then go to IDLE.
- A request is accepted only in IDLE. `cpu_req` held high through RESP is not re-accepted in that cycle.
- `dev_ack` from a non-selected slot, or while not in ACCESS, is ignored.
- Reset asserted mid-operation: FSM goes to IDLE. All outputs go to 0, including `dev_sel`, `cpu_ready`, `cpu_err`, `cpu_rdata`, `irq_out` and the pending register. An in-flight access is abandoned.

## Timing
- Edge 0 = the edge that samples `cpu_req` in IDLE.
- Hit: `dev_sel` is high from edge 0. With an ack sampled at edge k (k≥1), `cpu_ready` is high from edge k to edge k+1. Minimum latency is 2 cycles.
- Miss, misaligned, or IRQ register access: `cpu_ready` is high in the cycle after edge 0. Latency is 1 cycle.
- Timeout: `cpu_ready`+`cpu_err` follow TIMEOUT ACCESS cycles. Latency is TIMEOUT+1.
- The wait counter is log2(TIMEOUT+1) bits wide and never wraps.
- All outputs are registered; there is no combinational path from `cpu_*` inputs to `cpu_*` outputs.

## Configuration
- `SYS_BRIDGE_IRQ_LATCH_EN` defined:
  - `dev_irq` high sets a sticky pending bit; `irq_out` = pending.
  - When a CPU write clears a bit in the same cycle its `dev_irq` is high, set wins.
  - The IRQ register is decoded.
- Not defined:
  - `irq_out` = `dev_irq` delayed by one register stage; there is no pending state.
  - The IRQ register address decodes as a miss.

## Structure
- Package `sys_bridge_pkg` holds:
  - the FSM state enum (IDLE/ACCESS/RESP)
  - the default BASE_ADDR and DEV_SPAN
  - the IRQ register offset constant
  - the slot-index width function
- The sub-module `sys_bridge_irq` holds the pending latch / delay stage and the write-1-to-clear logic.
- The FSM, decoder and timeout counter stay in the top module.

## Test plan
- Read 0x7F14 (slot 1, offset 4); dev1 acks on the 3rd ACCESS cycle with 0xDEADBEEF → `dev_sel`=2'b10, `dev_addr`=4; then `cpu_ready`=1, `cpu_err`=0, `cpu_rdata`=0xDEADBEEF; total latency 4 cycles.
- Write 0x7F00, data 0x12345678, byteen 4'b0011; dev0 acks immediately → `dev_wdata`/`dev_byteen` match the request; `cpu_ready` at cycle 2, `cpu_err`=0.
- Access 0x7F30 (miss), then word access to 0x7F02 (misaligned) → each gives `cpu_ready`+`cpu_err` after 1 cycle; `dev_sel` stays 0.
- Read slot 0 with no ack, TIMEOUT=15 → `cpu_err`=1 and `cpu_rdata`=0 at cycle 16; a second run with the ack on cycle 15 returns data with `cpu_err`=0.
- With the macro defined: pulse `dev_irq[1]` for 1 cycle → `irq_out`=2'b10 and it stays set.
  - Read 0x7F20 → 0x2.
  - Write 0x2 to 0x7F20 → `irq_out`=0.
  - Repeat with `dev_irq[1]` held high during the clear → the bit stays 1.
- Assert `reset` low during ACCESS → all outputs 0 immediately; after release, a new read completes normally.
